// File: rtl/approx_add_arbiter_pkg.sv
// ============================================================================
// approx_add_pkg : shared types and helpers for the approximate-adder arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package approx_add_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width that stays legal for a single requester
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/approx_add_arbiter_if.sv
// ============================================================================
// approx_add_arbiter_if : request/response bundle for approx_add_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface approx_add_arbiter_if
  import approx_add_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
);

  localparam int ID_W = idx_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_exact;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH:0]        rsp_sum;
  logic [ID_W-1:0]       rsp_id;
  logic [CNT_W-1:0]      cnt_exact;
  logic [CNT_W-1:0]      cnt_approx;

  modport slave (
    input  req_valid, req_a, req_b, req_exact, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, cnt_exact, cnt_approx
  );

  modport master (
    output req_valid, req_a, req_b, req_exact, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, cnt_exact, cnt_approx
  );

endinterface

`default_nettype wire

// File: rtl/approx_add_arbiter_adder_core.sv
// ============================================================================
// adder_core : ripple-carry adder with an optional approximate low segment
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_core
  import approx_add_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             exact_i,
  output logic [WIDTH:0]   sum_o
);

  logic carry;

  // Approximate cell: S = X & ~Cin, Cout = 1, operand B ignored
  always_comb begin
    sum_o = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i < APPROX_BITS) && !exact_i) begin
        sum_o[i] = a_i[i] & ~carry;
        carry    = 1'b1;
      end else begin
        sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
        carry    = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
      end
    end
    sum_o[WIDTH] = carry;
  end

endmodule

`default_nettype wire

// File: rtl/approx_add_arbiter.sv
// ============================================================================
// approx_add_arbiter : round-robin sharing of one approximate adder
// Revision: 1.0
// ============================================================================
`default_nettype none

module approx_add_arbiter
  import approx_add_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int CNT_W       = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  approx_add_arbiter_if.slave bus
);

  localparam int ID_W = idx_w(NREQ);

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             exact_q;
  logic [ID_W-1:0]  id_q;
  logic             rsp_valid_q;
  logic [WIDTH:0]   rsp_sum_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [CNT_W-1:0] cnt_exact_q;
  logic [CNT_W-1:0] cnt_approx_q;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    scan_idx;
  logic [WIDTH:0]   core_sum;

  // First valid requester at or above rr_ptr, wrapping at NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NREQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NREQ);
      end
      if (!grant_found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  adder_core #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_adder_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .exact_i (exact_q),
    .sum_o   (core_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      exact_q      <= 1'b0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
      cnt_exact_q  <= '0;
      cnt_approx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            a_q      <= bus.req_a[grant_idx*WIDTH +: WIDTH];
            b_q      <= bus.req_b[grant_idx*WIDTH +: WIDTH];
            exact_q  <= bus.req_exact[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rsp_sum_q   <= core_sum;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          if (exact_q) begin
            if (cnt_exact_q != {CNT_W{1'b1}}) cnt_exact_q <= cnt_exact_q + 1'b1;
          end else begin
            if (cnt_approx_q != {CNT_W{1'b1}}) cnt_approx_q <= cnt_approx_q + 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.cnt_exact  = cnt_exact_q;
  assign bus.cnt_approx = cnt_approx_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_add_arbiter.sv
// ============================================================================
// tb_approx_add_arbiter : scoreboard bench for approx_add_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_approx_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  typedef struct {
    logic [W:0] sum;
    int         id;
  } exp_t;

  logic clk;
  logic rst_n;

  approx_add_arbiter_if #(.NREQ(NREQ), .WIDTH(W), .CNT_W(16)) bus ();

  approx_add_arbiter #(
    .NREQ        (NREQ),
    .WIDTH       (W),
    .APPROX_BITS (8),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];
  int   grant_log[$];

  int          m_state = 0;
  int          m_ptr   = 0;
  int          m_g;
  int          m_c;
  bit          m_ex;
  logic [15:0] m_ce = '0;
  logic [15:0] m_ca = '0;
  logic [3:0]  m_rdy;
  exp_t        m_e;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: low byte approximate gives {7'b0, a[0]} and a forced carry of 1
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input bit ex);
    if (ex) return {1'b0, a} + {1'b0, b};
    return {({1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1), 7'd0, a[0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_rsp_sum", bus.rsp_sum, 0);
      check_eq("rst_rsp_id", bus.rsp_id, 0);
      check_eq("rst_cnt_exact", bus.cnt_exact, 0);
      check_eq("rst_cnt_approx", bus.cnt_approx, 0);
      m_state = 0;
      m_ptr   = 0;
      m_ce    = '0;
      m_ca    = '0;
      sb.delete();
    end else begin
      check_eq("cnt_exact", bus.cnt_exact, m_ce);
      check_eq("cnt_approx", bus.cnt_approx, m_ca);
      case (m_state)
        0: begin
          m_g   = -1;
          m_rdy = '0;
          for (int k = 0; k < NREQ; k++) begin
            m_c = (m_ptr + k) % NREQ;
            if (m_g < 0 && bus.req_valid[m_c]) m_g = m_c;
          end
          if (m_g >= 0) m_rdy[m_g] = 1'b1;
          check_eq("idle_rsp_valid", bus.rsp_valid, 0);
          check_eq("req_ready_rr", bus.req_ready, m_rdy);
          if (m_g >= 0) begin
            m_ex  = bus.req_exact[m_g];
            m_e.sum = ref_sum(bus.req_a[m_g*W +: W], bus.req_b[m_g*W +: W], m_ex);
            m_e.id  = m_g;
            sb.push_back(m_e);
            grant_log.push_back(m_g);
            m_ptr   = (m_g + 1) % NREQ;
            m_state = 1;
          end
        end
        1: begin
          check_eq("calc_rsp_valid", bus.rsp_valid, 0);
          check_eq("calc_req_ready", bus.req_ready, 0);
          if (m_ex) m_ce = (m_ce == 16'hFFFF) ? m_ce : m_ce + 1'b1;
          else      m_ca = (m_ca == 16'hFFFF) ? m_ca : m_ca + 1'b1;
          m_state = 2;
        end
        default: begin
          check_eq("resp_rsp_valid", bus.rsp_valid, 1);
          check_eq("resp_req_ready", bus.req_ready, 0);
          if (bus.rsp_ready) begin
            if (sb.size() == 0) begin
              check_eq("sb_underflow", 1, 0);
            end else begin
              m_e = sb.pop_front();
              check_eq("sb_sum", bus.rsp_sum, m_e.sum);
              check_eq("sb_id", bus.rsp_id, m_e.id);
            end
            m_state = 0;
          end
        end
      endcase
    end
  end

  task automatic run_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input bit ex, input logic [16:0] exp_sum);
    int n;
    @(posedge clk); #1;
    bus.req_valid            = '0;
    bus.req_valid[idx]       = 1'b1;
    bus.req_a[idx*W +: W]    = a;
    bus.req_b[idx*W +: W]    = b;
    bus.req_exact[idx]       = ex;
    #1;
    n = 0;
    while (!bus.req_ready[idx] && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("one_grant", bus.req_ready[idx], 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check_eq("one_calc_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check_eq("one_latency_valid", bus.rsp_valid, 1);
    check_eq("one_sum", bus.rsp_sum, exp_sum);
    check_eq("one_id", bus.rsp_id, idx);
  endtask

  task automatic wait_grants(input int cnt);
    int n;
    n = 0;
    while (grant_log.size() < cnt && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("grant_timeout", (grant_log.size() >= cnt), 1);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_exact = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(0, 16'h1234, 16'h0101, 1'b1, 17'h01335);
    check_eq("dir_cnt_exact", bus.cnt_exact, 1);
    check_eq("dir_cnt_approx0", bus.cnt_approx, 0);
    run_one(1, 16'h1234, 16'h0101, 1'b0, 17'h01400);
    check_eq("dir_cnt_approx", bus.cnt_approx, 1);
    run_one(2, 16'hFFFF, 16'h0000, 1'b0, 17'h10001);
    run_one(3, 16'hFFFF, 16'h0000, 1'b1, 17'h0FFFF);

    // Round-robin with every requester held valid
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*W +: W] = 16'($urandom);
      bus.req_b[i*W +: W] = 16'($urandom);
      bus.req_exact[i]    = 1'($urandom);
    end
    grant_log.delete();
    bus.req_valid = '1;
    wait_grants(5);
    bus.req_valid = '0;
    check_eq("rr_g0", grant_log[0], 0);
    check_eq("rr_g1", grant_log[1], 1);
    check_eq("rr_g2", grant_log[2], 2);
    check_eq("rr_g3", grant_log[3], 3);
    check_eq("rr_g4", grant_log[4], 0);
    repeat (6) @(posedge clk);

    // Backpressure on the response port
    #1;
    bus.rsp_ready       = 1'b0;
    bus.req_a[2*W +: W] = 16'h00FF;
    bus.req_b[2*W +: W] = 16'h0001;
    bus.req_exact[2]    = 1'b1;
    bus.req_valid       = 4'b0100;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_valid", bus.rsp_valid, 1);
    bus.req_valid = '1;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", bus.rsp_valid, 1);
      check_eq("bp_hold_sum", bus.rsp_sum, 17'h00100);
      check_eq("bp_hold_id", bus.rsp_id, 2);
      check_eq("bp_no_grant", bus.req_ready, 0);
    end
    grant_log.delete();
    bus.rsp_ready = 1'b1;
    wait_grants(1);
    bus.req_valid = '0;
    check_eq("bp_next_grant", grant_log[0], 3);
    repeat (6) @(posedge clk);

    // Reset while the adder stage holds a transaction
    #1;
    bus.req_valid = 4'b0100;
    #1;
    n = 0;
    while (!bus.req_ready[2] && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("mr_grant", bus.req_ready[2], 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_async_valid", bus.rsp_valid, 0);
    check_eq("mr_async_cnt_e", bus.cnt_exact, 0);
    check_eq("mr_async_cnt_a", bus.cnt_approx, 0);
    check_eq("mr_async_ready", bus.req_ready, 0);
    bus.req_valid = 4'b1010;
    repeat (2) @(posedge clk);
    grant_log.delete();
    #1 rst_n = 1'b1;
    wait_grants(1);
    bus.req_valid = '0;
    check_eq("mr_first_grant", grant_log[0], 1);
    repeat (6) @(posedge clk);
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/approx_add_arbiter.md
Name: approx_add_arbiter

Overview:
- Shares one 16-bit ripple-carry adder, with an approximate low segment, between NREQ requesters.
- Each request carries two operands and a per-request mode bit: exact, or approximate in the low APPROX_BITS.
- Arbitration is round-robin. Operands are registered and the sum is computed in a registered stage. The result is held on a valid/ready response port.
- Saturating counters record how many additions ran in each mode, for power/error characterisation runs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width.
- APPROX_BITS, 8, number of approximate LSB cells (0..WIDTH; 0 means the adder is always exact).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same slicing.
- req_exact  in  NREQ  1 = exact add, 0 = approximate low segment.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_sum  out  WIDTH+1  sum including carry-out.
- rsp_id  out  clog2(NREQ)  index of the requester served.
- cnt_exact  out  CNT_W  saturating count of exact adds completed.
- cnt_approx  out  CNT_W  saturating count of approximate adds completed.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, both counters=0.
- FSM states:
  - IDLE: if any req_valid, pick the first valid index searching upward from rr_ptr, wrapping. req_ready[g] is driven high combinationally in the same cycle. On that edge, capture a, b, exact and id; set rr_ptr=(g+1) mod NREQ; go CALC. If no request is valid, stay in IDLE and drive req_ready=0.
  - CALC: adder_core evaluates the captured operands; the result is registered into rsp_sum and rsp_id; rsp_valid<=1; the matching counter is incremented (saturates at all-ones); go RESP. req_ready=0.
  - RESP: rsp_valid=1; rsp_sum and rsp_id are stable. When rsp_ready=1, rsp_valid<=0 and go IDLE. req_ready=0.
- Latency: handshake at edge t gives rsp_valid high after edge t+1. Best-case throughput is one result per 3 cycles.
- req_valid deasserting in IDLE before a grant simply removes that requester from arbitration. Requests are not buffered.
- Simultaneous requests are resolved by round-robin only. A requester that is continuously valid is served within NREQ grants.
- req_ready never asserts outside IDLE, and never to a requester whose req_valid is low.
- Arithmetic: the carry-in to bit 0 is 0. Bits [WIDTH-1:APPROX_BITS] are exact full adders: S=X^Y^Z, C=maj(X,Y,Z).
- Bits [APPROX_BITS-1:0] in approximate mode use the approximate cell: S = X & ~Z, Cout = 1 constant (Y is ignored).
- In exact mode all bits use exact full adders.
- rsp_sum[WIDTH] is the final carry-out.
- Reset asserted mid-operation: the transaction is abandoned, with no response and no counter update.

Decomposition:
- Shared package approx_add_pkg holds:
  - the state enum (IDLE, CALC, RESP);
  - the default WIDTH/APPROX_BITS constants;
  - an index-width function.
- Sub-module adder_core: purely combinational, parameterised by WIDTH and APPROX_BITS, with an exact-mode input. The arbiter, FSM and counters live in approx_add_arbiter.

Test Plan:
- Exact add: req 0, a=0x1234, b=0x0101, exact=1 -> rsp_sum=0x01335, rsp_id=0, rsp_valid two cycles after grant, cnt_exact=1.
- Approximate add: req 1, a=0x1234, b=0x0101, exact=0 -> rsp_sum=0x01400 (low byte = {7'b0,a[0]}, upper = 0x12+0x01+1), cnt_approx=1.
- Carry boundary: a=0xFFFF, b=0x0000, exact=0 -> rsp_sum=0x10001; same operands with exact=1 -> 0x0FFFF.
- Round-robin: all 4 requesters held valid -> grant order 0,1,2,3,0; req_ready is one-hot, high only in IDLE.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_sum/rsp_id stable, rsp_valid held, no new grant; release -> IDLE, next grant follows.
- Reset mid-CALC: rst_n low -> rsp_valid=0, counters=0, rr_ptr=0 immediately (async); first grant after release goes to the lowest valid index.
